// File: rtl/score_uart_reporter_if.sv
// rtl/score_uart_reporter_if.sv - byte-strobe UART transmit link (txdata/txclk paced by txready)
interface score_uart_reporter_if;
    logic [7:0] txdata;
    logic       txclk;
    logic       txready;

    modport master (output txdata, output txclk, input txready);
    modport slave  (input txdata, input txclk, output txready);
endinterface

// File: rtl/score_uart_reporter.sv
// rtl/score_uart_reporter.sv - formats score/game-over events as 6-byte ASCII lines on the UART link
module score_uart_reporter #(
    parameter int SETTLE = 4,
    parameter int TX_GAP = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          goodColl,
    input  logic                          badColl,
    input  logic                          isGameComplete,
    input  logic [3:0]                    bcd_hundreds,
    input  logic [3:0]                    bcd_tens,
    input  logic [3:0]                    bcd_ones,
    score_uart_reporter_if.master         tx,
    output logic                          busy,
    output logic [7:0]                    dropped
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] GAP_LAST    = 4'(TX_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_LOAD, S_WAIT_RDY, S_STROBE, S_GAP
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic        msg_g, msg_g_n;
    logic        pend_s, pend_g;
    logic        prev_good, prev_bad, prev_gc;
    logic [11:0] snap;
    logic [7:0]  txdata_q;
    logic [7:0]  cur_byte;
    logic        ev_s, ev_g;
    logic        take_s, take_g;
    logic        load_snap, load_byte;
    logic        drop_s, drop_g;
    logic [8:0]  drop_sum;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    assign ev_s = en & goodColl & ~prev_good;
    assign ev_g = en & ((badColl & ~prev_bad) | (isGameComplete & ~prev_gc));

    // An event that is consumed directly by IDLE in the same cycle is not a drop.
    assign drop_s   = ev_s & pend_s & ~take_s;
    assign drop_g   = ev_g & pend_g & ~take_g;
    assign drop_sum = {1'b0, dropped} + 9'(drop_s) + 9'(drop_g);

    always_comb begin
        cur_byte = 8'h0A;
        case (idx)
            3'd0:    cur_byte = msg_g ? 8'h47 : 8'h53;
            3'd1:    cur_byte = ascii_digit(snap[11:8]);
            3'd2:    cur_byte = ascii_digit(snap[7:4]);
            3'd3:    cur_byte = ascii_digit(snap[3:0]);
            3'd4:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        msg_g_n   = msg_g;
        take_s    = 1'b0;
        take_g    = 1'b0;
        load_snap = 1'b0;
        load_byte = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_g | ev_g) begin
                    take_g  = 1'b1;
                    msg_g_n = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = S_SETTLE;
                end else if (pend_s | ev_s) begin
                    take_s  = 1'b1;
                    msg_g_n = 1'b0;
                    cnt_n   = 4'd0;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == SETTLE_LAST) state_n = S_LOAD;
                else                    cnt_n   = cnt + 4'd1;
            end
            S_LOAD: begin
                load_snap = 1'b1;
                idx_n     = 3'd0;
                state_n   = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (tx.txready) begin
                    load_byte = 1'b1;
                    state_n   = S_STROBE;
                end
            end
            S_STROBE: begin
                cnt_n   = 4'd0;
                state_n = S_GAP;
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    if (idx == 3'd5) begin
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = S_WAIT_RDY;
                    end
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            idx       <= 3'd0;
            msg_g     <= 1'b0;
            pend_s    <= 1'b0;
            pend_g    <= 1'b0;
            prev_good <= 1'b0;
            prev_bad  <= 1'b0;
            prev_gc   <= 1'b0;
            snap      <= 12'h000;
            txdata_q  <= 8'h00;
            dropped   <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            msg_g     <= msg_g_n;
            prev_good <= goodColl;
            prev_bad  <= badColl;
            prev_gc   <= isGameComplete;
            // When a flag is consumed, a coincident event of the same kind re-arms it.
            if (take_s)    pend_s <= pend_s & ev_s;
            else if (ev_s) pend_s <= 1'b1;
            if (take_g)    pend_g <= pend_g & ev_g;
            else if (ev_g) pend_g <= 1'b1;
            if (load_snap) snap <= {bcd_hundreds, bcd_tens, bcd_ones};
            if (load_byte) txdata_q <= cur_byte;
            dropped <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign tx.txclk  = (state == S_STROBE);
    assign tx.txdata = txdata_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_score_uart_reporter.sv
// tb/tb_score_uart_reporter.sv - scoreboard bench for score_uart_reporter
module tb_score_uart_reporter;
    localparam int SP    = 4;
    localparam int GP    = 2;
    localparam int SPACE = GP + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       goodColl;
    logic       badColl;
    logic       isGameComplete;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;
    logic [7:0] dropped;

    score_uart_reporter_if tx_if ();

    score_uart_reporter #(.SETTLE(SP), .TX_GAP(GP)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .isGameComplete (isGameComplete),
        .bcd_hundreds   (bcd_hundreds),
        .bcd_tens       (bcd_tens),
        .bcd_ones       (bcd_ones),
        .tx             (tx_if),
        .busy           (busy),
        .dropped        (dropped)
    );

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   nstrobe  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (tx_if.txclk === 1'b1) begin
            nstrobe++;
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe cyc=%0d actual=%02h required=none", cyc, tx_if.txdata);
            end else begin
                e = expq.pop_front();
                if (tx_if.txdata !== e.b) begin
                    failures++;
                    $display("FAIL tx_byte cyc=%0d actual=%02h required=%02h", cyc, tx_if.txdata, e.b);
                end
                if (e.t >= 0) begin
                    checks++;
                    if (cyc != e.t) begin
                        failures++;
                        $display("FAIL strobe_time actual=%0d required=%0d", cyc, e.t);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    function automatic logic [7:0] digit_char(input int d);
        return (d <= 9) ? 8'(8'h30 + d) : 8'h3F;
    endfunction

    // first < 0 means timing is not checked; extra delays bytes 2..5 (handshake stall)
    task automatic push_msg(input bit g, input int hh, input int tt, input int oo,
                            input int first, input int extra, input int nbytes);
        logic [7:0] m[6];
        exp_t e;
        m[0] = g ? 8'h47 : 8'h53;
        m[1] = digit_char(hh);
        m[2] = digit_char(tt);
        m[3] = digit_char(oo);
        m[4] = 8'h0D;
        m[5] = 8'h0A;
        for (int k = 0; k < nbytes; k++) begin
            e.b = m[k];
            e.t = (first < 0) ? -1 : first + k * SPACE + ((k >= 2) ? extra : 0);
            expq.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || expq.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 3000), 32'd1);
    endtask

    task automatic pulse_good();
        goodColl = 1'b1;
        tick();
        goodColl = 1'b0;
        tick();
    endtask

    task automatic set_digits(input int hh, input int tt, input int oo);
        bcd_hundreds = 4'(hh);
        bcd_tens     = 4'(tt);
        bcd_ones     = 4'(oo);
    endtask

    initial begin
        int e, f, hh, tt, oo, n0, len;
        rst = 1'b1; en = 1'b1;
        goodColl = 1'b0; badColl = 1'b0; isGameComplete = 1'b0;
        set_digits(0, 0, 0);
        tx_if.txready = 1'b1;
        repeat (3) tick();
        chk("reset_txclk", 32'(tx_if.txclk), 32'd0);
        chk("reset_txdata", 32'(tx_if.txdata), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        tick();

        // Score 012 with exact strobe timing
        set_digits(0, 1, 2);
        e = cyc;
        push_msg(0, 0, 1, 2, e + SP + 3, 0, 6);
        pulse_good();
        wait_done("score012_done");
        chk("score012_busy", 32'(busy), 32'd0);
        chk("score012_dropped", 32'(dropped), 32'd0);

        // Simultaneous game-over and apple: G first, S one IDLE cycle later
        hh = $urandom_range(0, 15); tt = $urandom_range(0, 15); oo = $urandom_range(0, 15);
        set_digits(hh, tt, oo);
        e = cyc;
        f = e + SP + 3;
        push_msg(1, hh, tt, oo, f, 0, 6);
        push_msg(0, hh, tt, oo, f + 5 * SPACE + GP + 1 + SP + 3, 0, 6);
        badColl = 1'b1; goodColl = 1'b1;
        tick();
        badColl = 1'b0; goodColl = 1'b0;
        wait_done("gs_order_done");

        // badColl and isGameComplete together are a single game-over
        e = cyc;
        push_msg(1, hh, tt, oo, e + SP + 3, 0, 6);
        badColl = 1'b1; isGameComplete = 1'b1;
        tick();
        badColl = 1'b0; isGameComplete = 1'b0;
        wait_done("merge_done");
        chk("merge_dropped", 32'(dropped), 32'd0);

        // txready stall after byte 1
        hh = $urandom_range(0, 9); tt = $urandom_range(0, 9); oo = $urandom_range(0, 9);
        set_digits(hh, tt, oo);
        len = 20;
        e = cyc;
        f = e + SP + 3;
        push_msg(0, hh, tt, oo, f, len + 2 - SPACE, 6);
        pulse_good();
        wait_until(f + SPACE + 1);
        tx_if.txready = 1'b0;
        repeat (len) tick();
        tx_if.txready = 1'b1;
        wait_done("stall_done");

        // Overflow: three extra pulses during an S message
        push_msg(0, hh, tt, oo, -1, 0, 6);
        push_msg(0, hh, tt, oo, -1, 0, 6);
        pulse_good();
        repeat (3) pulse_good();
        wait_done("overflow_done");
        chk("overflow_dropped", 32'(dropped), 32'd2);

        // Saturation while the transmitter is stalled
        tx_if.txready = 1'b0;
        push_msg(0, hh, tt, oo, -1, 0, 6);
        push_msg(0, hh, tt, oo, -1, 0, 6);
        pulse_good();
        repeat (300) pulse_good();
        chk("saturate_dropped", 32'(dropped), 32'hFF);
        chk("saturate_busy", 32'(busy), 32'd1);
        tx_if.txready = 1'b1;
        wait_done("saturate_done");

        // Digit snapshot plus invalid ones digit
        hh = $urandom_range(0, 9); tt = $urandom_range(0, 4); oo = 12;
        set_digits(hh, tt, oo);
        e = cyc;
        push_msg(0, hh, tt, oo, e + SP + 3, 0, 6);
        pulse_good();
        wait_until(e + SP + 3);
        bcd_tens = 4'd5;
        wait_done("snapshot_done");

        // en=0 ignores events
        en = 1'b0;
        n0 = nstrobe;
        pulse_good();
        badColl = 1'b1; tick(); badColl = 1'b0; tick();
        repeat (40) tick();
        chk("en0_strobes", 32'(nstrobe - n0), 32'd0);
        chk("en0_busy", 32'(busy), 32'd0);
        en = 1'b1;
        tick();

        // Reset during byte 2's gap with both flags pending
        hh = $urandom_range(0, 9); tt = $urandom_range(0, 9); oo = $urandom_range(0, 9);
        set_digits(hh, tt, oo);
        e = cyc;
        f = e + SP + 3;
        push_msg(0, hh, tt, oo, f, 0, 3);
        pulse_good();
        badColl = 1'b1; tick(); badColl = 1'b0; tick();
        pulse_good();
        wait_until(f + 2 * SPACE + 1);
        rst = 1'b1;
        tick();
        chk("midrst_txclk", 32'(tx_if.txclk), 32'd0);
        chk("midrst_txdata", 32'(tx_if.txdata), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dropped", 32'(dropped), 32'd0);
        rst = 1'b0;
        n0 = nstrobe;
        repeat (80) tick();
        chk("midrst_no_strobes", 32'(nstrobe - n0), 32'd0);
        chk("midrst_queue_empty", 32'(expq.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
